// File: rtl/stream_fifo_pkg.sv
// Shared FIFO definitions: default geometry, occupancy-counter width rule and
// the registered status-flag bundle used by the stream and UART FIFOs.
package stream_fifo_pkg;

   localparam int FIFO_DATA_WIDTH_DEF   = 64;
   localparam int FIFO_DEPTH_LOG2_DEF   = 3;
   localparam int FIFO_AE_THR_DEF       = 1;
   localparam int FIFO_DROP_ON_FULL_DEF = 0;

   // Occupancy runs 0..2**depth_log2 inclusive, so it needs one extra bit.
   function automatic int fifo_count_width(input int depth_log2);
      return depth_log2 + 1;
   endfunction

   function automatic int fifo_af_thr_def(input int depth_log2);
      return (1 << depth_log2) - 1;
   endfunction

   typedef struct packed {
      logic full;
      logic empty;
      logic almost_full;
      logic almost_empty;
   } fifo_flags_t;

   localparam fifo_flags_t FIFO_FLAGS_RST = '{
      full:         1'b0,
      empty:        1'b1,
      almost_full:  1'b0,
      almost_empty: 1'b1
   };

endpackage

// File: rtl/fifo_regfile.sv
// FIFO storage: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset.
module fifo_regfile #(
   parameter int DATA_WIDTH = 64,
   parameter int DEPTH_LOG2 = 3
) (
   input  logic                  i_clk,
   input  logic                  i_we,
   input  logic [DEPTH_LOG2-1:0] i_waddr,
   input  logic [DATA_WIDTH-1:0] i_wdata,
   input  logic [DEPTH_LOG2-1:0] i_raddr,
   output logic [DATA_WIDTH-1:0] o_rdata
);

   logic [DATA_WIDTH-1:0] r_mem [2**DEPTH_LOG2];

   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/stream_fifo.sv
// First-word fall-through stream FIFO with registered status flags and an
// optional drop-on-full mode that keeps s_ready high and records overflow.
module stream_fifo
   import stream_fifo_pkg::*;
#(
   parameter int DATA_WIDTH   = FIFO_DATA_WIDTH_DEF,
   parameter int DEPTH_LOG2   = FIFO_DEPTH_LOG2_DEF,
   parameter int AF_THR       = fifo_af_thr_def(DEPTH_LOG2),
   parameter int AE_THR       = FIFO_AE_THR_DEF,
   parameter int DROP_ON_FULL = FIFO_DROP_ON_FULL_DEF
) (
   input  logic                                    clk,
   input  logic                                    rst,
   input  logic                                    flush,
   input  logic [DATA_WIDTH-1:0]                   s_data,
   input  logic                                    s_valid,
   output logic                                    s_ready,
   output logic [DATA_WIDTH-1:0]                   m_data,
   output logic                                    m_valid,
   input  logic                                    m_ready,
   output logic [fifo_count_width(DEPTH_LOG2)-1:0] count,
   output logic                                    full,
   output logic                                    empty,
   output logic                                    almost_full,
   output logic                                    almost_empty,
   output logic                                    overflow
);

   localparam int              CW      = fifo_count_width(DEPTH_LOG2);
   localparam logic [CW-1:0]   DEPTH_C = CW'(2**DEPTH_LOG2);
   localparam logic [CW-1:0]   AF_C    = CW'(AF_THR);
   localparam logic [CW-1:0]   AE_C    = CW'(AE_THR);

   logic [DEPTH_LOG2-1:0] r_wptr;
   logic [DEPTH_LOG2-1:0] r_rptr;
   logic [CW-1:0]         r_count;
   fifo_flags_t           r_flags;
   logic                  r_overflow;
   logic                  r_rst_done;

   logic [CW-1:0]         w_count_nxt;
   fifo_flags_t           w_flags_nxt;
   logic                  w_s_ready;
   logic                  w_wr;
   logic                  w_rd;
   logic                  w_ovf_set;
   logic [DATA_WIDTH-1:0] w_rdata;

   // s_ready is built only from registers, so m_ready never reaches it
   // combinationally; r_rst_done holds it low until the first edge after reset.
   assign w_s_ready = r_rst_done && ((DROP_ON_FULL != 0) || !r_flags.full);

   // In drop mode a write is gated by the registered full flag, so a same-edge
   // read does not open a slot for it.
   assign w_wr      = s_valid && w_s_ready && !r_flags.full;
   assign w_rd      = !r_flags.empty && m_ready;
   assign w_ovf_set = (DROP_ON_FULL != 0) && s_valid && w_s_ready && r_flags.full;

   always_comb begin
      w_count_nxt = r_count;
      unique case ({w_wr, w_rd})
         2'b10:   w_count_nxt = r_count + CW'(1);
         2'b01:   w_count_nxt = r_count - CW'(1);
         default: w_count_nxt = r_count;
      endcase
   end

   always_comb begin
      w_flags_nxt              = FIFO_FLAGS_RST;
      w_flags_nxt.full         = (w_count_nxt == DEPTH_C);
      w_flags_nxt.empty        = (w_count_nxt == '0);
      w_flags_nxt.almost_full  = (w_count_nxt >= AF_C);
      w_flags_nxt.almost_empty = (w_count_nxt <= AE_C);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_count    <= '0;
         r_flags    <= FIFO_FLAGS_RST;
         r_overflow <= 1'b0;
         r_rst_done <= 1'b0;
      end else begin
         r_rst_done <= 1'b1;
         if (flush) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_flags    <= FIFO_FLAGS_RST;
            r_overflow <= 1'b0;
         end else begin
            if (w_wr) begin
               r_wptr <= r_wptr + DEPTH_LOG2'(1);
            end
            if (w_rd) begin
               r_rptr <= r_rptr + DEPTH_LOG2'(1);
            end
            r_count <= w_count_nxt;
            r_flags <= w_flags_nxt;
            if (w_ovf_set) begin
               r_overflow <= 1'b1;
            end
         end
      end
   end

   fifo_regfile #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_regfile (
      .i_clk   (clk),
      .i_we    (w_wr),
      .i_waddr (r_wptr),
      .i_wdata (s_data),
      .i_raddr (r_rptr),
      .o_rdata (w_rdata)
   );

   assign s_ready      = w_s_ready;
   assign m_data       = w_rdata;
   assign m_valid      = !r_flags.empty;
   assign count        = r_count;
   assign full         = r_flags.full;
   assign empty        = r_flags.empty;
   assign almost_full  = r_flags.almost_full;
   assign almost_empty = r_flags.almost_empty;
   assign overflow     = r_overflow;

endmodule
